// File: rtl/branch_resolve_bht_if.sv
// Bundle of fetch-prediction, EX-resolution, comparator and redirect signals
// exchanged between the pipeline (master) and the branch unit (slave).
interface branch_resolve_bht_if #(
   parameter int CNT_W = 16
);
   logic             f_valid_i;
   logic [31:0]      f_pc_i;
   logic             f_pred_taken_o;
   logic             ex_valid_i;
   logic [31:0]      ex_pc_i;
   logic [2:0]       ex_funct3_i;
   logic [31:0]      ex_target_i;
   logic             ex_pred_taken_i;
   logic             BrUn_o;
   logic             BrEq_i;
   logic             BrLt_i;
   logic             ex_taken_o;
   logic             redirect_o;
   logic [31:0]      redirect_pc_o;
   logic             flush_o;
   logic [CNT_W-1:0] branch_cnt_o;
   logic [CNT_W-1:0] mispred_cnt_o;

   modport master (
      output f_valid_i, f_pc_i, ex_valid_i, ex_pc_i, ex_funct3_i,
             ex_target_i, ex_pred_taken_i, BrEq_i, BrLt_i,
      input  f_pred_taken_o, BrUn_o, ex_taken_o, redirect_o,
             redirect_pc_o, flush_o, branch_cnt_o, mispred_cnt_o
   );

   modport slave (
      input  f_valid_i, f_pc_i, ex_valid_i, ex_pc_i, ex_funct3_i,
             ex_target_i, ex_pred_taken_i, BrEq_i, BrLt_i,
      output f_pred_taken_o, BrUn_o, ex_taken_o, redirect_o,
             redirect_pc_o, flush_o, branch_cnt_o, mispred_cnt_o
   );
endinterface

// File: rtl/branch_resolve_bht.sv
// Branch resolution and 2-bit BHT prediction unit. Resolves the EX branch
// combinationally from the comparator flags, trains the BHT, issues a
// registered one-cycle redirect/flush on mispredict and keeps statistics.
module branch_resolve_bht #(
   parameter int IDX_W = 6,
   parameter int CNT_W = 16
) (
   input logic                clk_i,
   input logic                rst_ni,
   branch_resolve_bht_if.slave bus
);

   localparam int                 ENTRIES = 1 << IDX_W;
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;
   localparam logic [1:0]         WEAK_NT = 2'b01;

   // 2-bit saturating counter step toward the resolved direction.
   function automatic logic [1:0] bht_step(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != 2'b11) nxt = cnt + 2'd1;
      end else begin
         if (cnt != 2'b00) nxt = cnt - 2'd1;
      end
      return nxt;
   endfunction

   // Statistics increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   logic [1:0]       bht [ENTRIES];
   logic             redirect_p1;
   logic [31:0]      redirect_pc_p1;
   logic [CNT_W-1:0] branch_cnt_p1;
   logic [CNT_W-1:0] mispred_cnt_p1;

   logic [IDX_W-1:0] f_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             legal;
   logic             cond;
   logic             taken;
   logic             eff_v;
   logic             mis;
   logic [31:0]      next_pc;
   logic             unused_pc_bits;

   assign f_idx  = bus.f_pc_i[IDX_W+1:2];
   assign ex_idx = bus.ex_pc_i[IDX_W+1:2];

   // Low PC bits never matter for word-aligned instructions; upper fetch
   // bits are outside the table index.
   assign unused_pc_bits = ^{bus.f_pc_i[31:IDX_W+2], bus.f_pc_i[1:0], bus.ex_pc_i[1:0]};

   // Fetch-side prediction: MSB of the indexed counter, no update bypass.
   assign bus.f_pred_taken_o = bus.f_valid_i & bht[f_idx][1];

   // Comparator signedness follows funct3[1] (bltu/bgeu).
   assign bus.BrUn_o = bus.ex_funct3_i[1];

   // Decode funct3 into a raw branch condition and legality.
   always_comb begin
      legal = 1'b1;
      cond  = 1'b0;
      case (bus.ex_funct3_i)
         3'b000:          cond = bus.BrEq_i;
         3'b001:          cond = ~bus.BrEq_i;
         3'b100, 3'b110:  cond = bus.BrLt_i;
         3'b101, 3'b111:  cond = ~bus.BrLt_i;
         default: begin
            legal = 1'b0;
            cond  = 1'b0;
         end
      endcase
   end

   assign taken          = bus.ex_valid_i & legal & cond;
   assign bus.ex_taken_o = taken;

   // A branch seen while a redirect is out is wrong-path and is dropped.
   assign eff_v   = bus.ex_valid_i & ~redirect_p1 & legal;
   assign mis     = eff_v & (taken != bus.ex_pred_taken_i);
   assign next_pc = taken ? bus.ex_target_i : bus.ex_pc_i + 32'd4;

   // BHT training on every effective branch; reset to weakly not-taken.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht[i] <= WEAK_NT;
         end
      end else if (eff_v) begin
         bht[ex_idx] <= bht_step(bht[ex_idx], taken);
      end
   end

   // EX -> redirect stage: one-cycle redirect pulse and held correct PC.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         redirect_p1    <= 1'b0;
         redirect_pc_p1 <= 32'd0;
      end else begin
         redirect_p1 <= mis;
         if (mis) begin
            redirect_pc_p1 <= next_pc;
         end
      end
   end

   // Saturating statistics on effective branches and mispredicts.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         branch_cnt_p1  <= '0;
         mispred_cnt_p1 <= '0;
      end else begin
         if (eff_v) branch_cnt_p1  <= sat_inc(branch_cnt_p1);
         if (mis)   mispred_cnt_p1 <= sat_inc(mispred_cnt_p1);
      end
   end

   assign bus.redirect_o    = redirect_p1;
   assign bus.flush_o       = redirect_p1;
   assign bus.redirect_pc_o = redirect_pc_p1;
   assign bus.branch_cnt_o  = branch_cnt_p1;
   assign bus.mispred_cnt_o = mispred_cnt_p1;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Self-checking bench for branch_resolve_bht: directed plan steps with
// literal expectations, then randomized traffic against a behavioural model.
module tb_branch_resolve_bht;

   localparam int IDX_W = 6;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam int NENT  = 1 << IDX_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_resolve_bht_if #(.CNT_W(CNT_W)) bus ();

   branch_resolve_bht #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // Operands of the branch; the bench plays the comparator.
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   assign bus.BrEq_i = (op_a == op_b);
   assign bus.BrLt_i = bus.ex_funct3_i[1] ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));

   int checks = 0;
   int failures = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Architectural meaning of each branch, from the operand values.
   function automatic bit arch_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 0;
      endcase
   endfunction

   function automatic int idx_of(input logic [31:0] pc);
      return int'(pc / 4) % NENT;
   endfunction

   // Behavioural model state.
   int          m_bht [NENT];
   int          m_bcnt = 0;
   int          m_mcnt = 0;
   bit          m_red = 0;
   logic [31:0] m_rpc = 32'd0;
   bit          m_live = 0;

   always @(posedge clk) begin
      bit legal, t, eff, mis;
      int k;
      if (!rst_n) begin
         foreach (m_bht[i]) m_bht[i] = 1;
         m_bcnt = 0;
         m_mcnt = 0;
         m_red  = 0;
         m_rpc  = 32'd0;
         m_live = 1;
      end else begin
         legal = !(bus.ex_funct3_i == 3'd2 || bus.ex_funct3_i == 3'd3);
         t     = bus.ex_valid_i && arch_taken(bus.ex_funct3_i, op_a, op_b);
         eff   = bus.ex_valid_i && !m_red && legal;
         mis   = eff && (t != bus.ex_pred_taken_i);
         m_red = mis;
         if (mis) m_rpc = t ? bus.ex_target_i : bus.ex_pc_i + 32'd4;
         if (eff) begin
            k = idx_of(bus.ex_pc_i);
            m_bht[k] = t ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3)
                         : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
            m_bcnt = (m_bcnt < CMAX) ? m_bcnt + 1 : CMAX;
            if (mis) m_mcnt = (m_mcnt < CMAX) ? m_mcnt + 1 : CMAX;
         end
      end
   end

   // Compare every DUT output against the model away from the active edge.
   always @(negedge clk) begin
      if (m_live) begin
         chk("f_pred", bus.f_pred_taken_o,
             bus.f_valid_i && (m_bht[idx_of(bus.f_pc_i)] >= 2));
         chk("ex_taken", bus.ex_taken_o,
             bus.ex_valid_i && arch_taken(bus.ex_funct3_i, op_a, op_b));
         chk("brun", bus.BrUn_o, (bus.ex_funct3_i == 3'd6 || bus.ex_funct3_i == 3'd7 ||
                                  bus.ex_funct3_i == 3'd2 || bus.ex_funct3_i == 3'd3));
         chk("redirect", bus.redirect_o, m_red);
         chk("flush", bus.flush_o, m_red);
         chk("redirect_pc", bus.redirect_pc_o, m_rpc);
         chk("branch_cnt", bus.branch_cnt_o, m_bcnt);
         chk("mispred_cnt", bus.mispred_cnt_o, m_mcnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input bit v, input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] tgt, input bit pred);
      bus.ex_valid_i      = v;
      bus.ex_pc_i         = pc;
      bus.ex_funct3_i     = f3;
      op_a                = a;
      op_b                = b;
      bus.ex_target_i     = tgt;
      bus.ex_pred_taken_i = pred;
   endtask

   initial begin
      bus.f_valid_i = 1'b0;
      bus.f_pc_i    = 32'd0;
      set_ex(0, 32'd0, 3'd0, 32'd0, 32'd0, 32'd0, 0);

      // 1: reset state
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      bus.f_valid_i = 1'b1;
      bus.f_pc_i    = 32'h100;
      #1;
      chk("t1_pred", bus.f_pred_taken_o, 0);
      chk("t1_redirect", bus.redirect_o, 0);
      chk("t1_bcnt", bus.branch_cnt_o, 0);
      chk("t1_mcnt", bus.mispred_cnt_o, 0);

      // 2: taken beq predicted not-taken
      set_ex(1, 32'h100, 3'd0, 32'd5, 32'd5, 32'h140, 0);
      #1;
      chk("t2_taken", bus.ex_taken_o, 1);
      tick();
      chk("t2_redirect", bus.redirect_o, 1);
      chk("t2_flush", bus.flush_o, 1);
      chk("t2_rpc", bus.redirect_pc_o, 32'h140);
      chk("t2_mcnt", bus.mispred_cnt_o, 1);
      chk("t2_model_bht", m_bht[idx_of(32'h100)], 2);
      bus.ex_valid_i = 1'b0;
      tick();

      // 3: three correctly predicted taken beqs, then a mispredicted bne
      set_ex(1, 32'h100, 3'd0, 32'd7, 32'd7, 32'h140, 1);
      repeat (3) tick();
      chk("t3_bcnt", bus.branch_cnt_o, 4);
      chk("t3_redirect", bus.redirect_o, 0);
      chk("t3_model_bht", m_bht[idx_of(32'h100)], 3);
      set_ex(1, 32'h100, 3'd1, 32'd7, 32'd7, 32'h140, 1);
      tick();
      chk("t3_rpc", bus.redirect_pc_o, 32'h104);
      chk("t3_redirect2", bus.redirect_o, 1);
      chk("t3_model_bht2", m_bht[idx_of(32'h100)], 2);
      bus.ex_valid_i = 1'b0;
      tick();

      // 4: comparator signedness select
      set_ex(1, 32'h180, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h1C0, 0);
      #1;
      chk("t4_brun_bltu", bus.BrUn_o, 1);
      chk("t4_bltu_taken", bus.ex_taken_o, 0);
      tick();
      set_ex(1, 32'h180, 3'd5, 32'd1, 32'd2, 32'h1C0, 0);
      #1;
      chk("t4_brun_bge", bus.BrUn_o, 0);
      chk("t4_bge_taken", bus.ex_taken_o, 0);
      tick();
      chk("t4_bcnt", bus.branch_cnt_o, 7);

      // 5: back-to-back mispredicts, then an illegal funct3
      set_ex(1, 32'h208, 3'd0, 32'd3, 32'd3, 32'h300, 0);
      tick();
      set_ex(1, 32'h30C, 3'd0, 32'd3, 32'd3, 32'h400, 0);
      tick();
      chk("t5_redirect", bus.redirect_o, 0);
      chk("t5_bcnt", bus.branch_cnt_o, 8);
      chk("t5_model_bht", m_bht[idx_of(32'h30C)], 1);
      set_ex(1, 32'h30C, 3'd2, 32'd3, 32'd4, 32'h400, 1);
      #1;
      chk("t5_illegal_taken", bus.ex_taken_o, 0);
      tick();
      chk("t5_illegal_redirect", bus.redirect_o, 0);
      chk("t5_illegal_bcnt", bus.branch_cnt_o, 8);

      // 6: same-index read during update, then reset during a mispredict
      bus.f_pc_i = 32'h410;
      set_ex(1, 32'h410, 3'd0, 32'd9, 32'd9, 32'h500, 0);
      #1;
      chk("t6_old_pred", bus.f_pred_taken_o, 0);
      tick();
      chk("t6_new_pred", bus.f_pred_taken_o, 1);
      bus.ex_valid_i = 1'b0;
      tick();
      set_ex(1, 32'h410, 3'd1, 32'd9, 32'd9, 32'h500, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.ex_valid_i = 1'b0;
      tick();
      chk("t6_rst_redirect", bus.redirect_o, 0);
      chk("t6_rst_bcnt", bus.branch_cnt_o, 0);
      chk("t6_rst_rpc", bus.redirect_pc_o, 0);

      // Randomized traffic over a few table entries.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a, b;
         a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3)) - 32'd2;
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = ~a;
            default: b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3)) - 32'd2;
         endcase
         bus.f_valid_i = 1'($urandom_range(0, 3) != 0);
         bus.f_pc_i    = 32'h1000 + 32'($urandom_range(0, 7)) * 4 + (($urandom_range(0, 1) == 1) ? 32'h100 : 32'h0);
         set_ex(1'($urandom_range(0, 3) != 0),
                32'h1000 + 32'($urandom_range(0, 7)) * 4,
                3'($urandom_range(0, 7)), a, b,
                $urandom & 32'hFFFF_FFFC,
                1'($urandom_range(0, 1)));
         rst_n = ($urandom_range(0, 299) != 0);
         tick();
      end

      rst_n = 1'b1;
      bus.ex_valid_i = 1'b0;
      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
